// File: rtl/acu_ctrl.sv
// acu_ctrl: three-cycle instruction sequencer (FETCH/DECODE/EXEC) driving the
// accumulator/ALU pair, register file and program ROM, with flag-based jumps.
module acu_ctrl #(
    parameter int UNDEFINED   = 0,
    parameter int CNTR_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int REG_BIT_CNT = 3,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [CNTR_WIDTH-1:0]  prog_addr,
    input  logic [DATA_WIDTH-1:0]  prog_data,
    output logic [ADDR_WIDTH-1:0]  alu_op,
    output logic                   acc_we,
    output logic [REG_BIT_CNT-1:0] reg_addr,
    output logic                   reg_we,
    input  logic                   zero_f,
    input  logic                   ls_z_f,
    input  logic                   gr_z_f,
    output logic                   busy,
    output logic                   halted,
    output logic [CNTR_WIDTH-1:0]  instr_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    // Control opcodes occupy the top of the opcode space.
    localparam logic [ADDR_WIDTH-1:0] OP_NOP  = ADDR_WIDTH'(UNDEFINED);
    localparam logic [ADDR_WIDTH-1:0] OP_HALT = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] OP_JLZ  = OP_HALT - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OP_JZ   = OP_HALT - ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] OP_JMP  = OP_HALT - ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] OP_JGZ  = OP_HALT - ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] OP_ST   = OP_HALT - ADDR_WIDTH'(5);

    logic [2:0]             state;
    logic [2:0]             state_next;
    logic [CNTR_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0]  ir;
    logic                   fz, fl, fg;

    logic [ADDR_WIDTH-1:0]  op;
    logic [REG_BIT_CNT-1:0] rsel;
    logic [CNTR_WIDTH-1:0]  tgt;
    logic                   is_st, is_halt, is_alu, take_jump;
    logic                   unused_ir;

    assign op        = ir[DATA_WIDTH-1 -: ADDR_WIDTH];
    assign rsel      = ir[REG_BIT_CNT-1:0];
    assign tgt       = ir[CNTR_WIDTH-1:0];
    assign prog_addr = pc;
    // Bits between the opcode and target fields are not decoded.
    assign unused_ir = ^ir;

    // Instruction class decode and jump resolution from the latched flags.
    always_comb begin
        is_st     = (op == OP_ST);
        is_halt   = (op == OP_HALT);
        is_alu    = !(op == OP_NOP || op == OP_ST || op == OP_JGZ || op == OP_JMP ||
                      op == OP_JZ || op == OP_JLZ || op == OP_HALT);
        take_jump = (op == OP_JMP) || ((op == OP_JZ) && fz) ||
                    ((op == OP_JLZ) && fl) || ((op == OP_JGZ) && fg);
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_next = S_FETCH;
            S_FETCH:        state_next = S_DECODE;
            S_DECODE:       state_next = S_EXEC;
            S_EXEC:         state_next = is_halt ? S_HALT : S_FETCH;
            default:        state_next = S_IDLE;
        endcase
    end

    // State register; busy/halted are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            busy   <= (state_next == S_FETCH) || (state_next == S_DECODE) ||
                      (state_next == S_EXEC);
            halted <= (state_next == S_HALT);
        end
    end

    // Program counter, instruction register, flags and instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            fz        <= 1'b0;
            fl        <= 1'b0;
            fg        <= 1'b0;
            instr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc        <= '0;
                        fz        <= 1'b0;
                        fl        <= 1'b0;
                        fg        <= 1'b0;
                        instr_cnt <= '0;
                    end
                end
                S_DECODE: ir <= prog_data;
                S_EXEC: begin
                    pc <= take_jump ? tgt : pc + CNTR_WIDTH'(1);
                    if (instr_cnt != '1) instr_cnt <= instr_cnt + CNTR_WIDTH'(1);
                    if (is_alu) begin
                        fz <= zero_f;
                        fl <= ls_z_f;
                        fg <= gr_z_f;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath strobes, asserted only during the EXEC cycle.
    always_comb begin
        alu_op   = OP_NOP;
        acc_we   = 1'b0;
        reg_we   = 1'b0;
        reg_addr = '0;
        if (state == S_EXEC) begin
            if (is_alu) begin
                alu_op   = op;
                reg_addr = rsel;
                acc_we   = 1'b1;
            end else if (is_st) begin
                reg_addr = rsel;
                reg_we   = 1'b1;
            end
        end
    end

endmodule
